// File: rtl/input_conditioner_if.sv
// -----------------------------------------------------------------------------
// input_conditioner_if
// Groups the board-side key/switch inputs and the conditioned CPU-side outputs
// of input_conditioner into one bundle. Clock and reset stay plain ports.
//   ready_raw  raw ReadyIn key, asynchronous
//   sw_raw     raw switches [7:0], asynchronous
//   ready_out  stretched ready level to the CPU
//   sw_out     conditioned switch value to the CPU
//   busy       conditioner FSM is not IDLE
// Modports: master = board/driver side, slave = the conditioner itself.
// -----------------------------------------------------------------------------
interface input_conditioner_if;
  logic       ready_raw;
  logic [7:0] sw_raw;
  logic       ready_out;
  logic [7:0] sw_out;
  logic       busy;

  modport master (
    output ready_raw,
    output sw_raw,
    input  ready_out,
    input  sw_out,
    input  busy
  );

  modport slave (
    input  ready_raw,
    input  sw_raw,
    output ready_out,
    output sw_out,
    output busy
  );
endinterface

// File: rtl/input_conditioner.sv
// -----------------------------------------------------------------------------
// input_conditioner
// Board-input front end on the fastclk domain. Synchronises and debounces the
// ReadyIn key and the 8 switches, turns each accepted press into a ready level
// HOLD_CYCLES long so a slow divided CPU clock can sample it, and presents a
// switch value that is stable while ready is high.
// Ports:
//   fastclk  in   board clock, all state on its rising edge
//   n_reset  in   asynchronous active-low reset
//   io       slave modport of input_conditioner_if
//            (ready_raw, sw_raw in; ready_out, sw_out, busy out)
// Configuration macro: INPUT_COND_SW_LIVE_EN
//   defined   : sw_out follows the debounced switches every cycle
//   undefined : sw_out is captured only when a press is accepted
// -----------------------------------------------------------------------------
module input_conditioner #(
  parameter int unsigned DB_CYCLES      = 1_000_000,
  parameter int unsigned HOLD_CYCLES    = 67_108_864,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input logic                fastclk,
  input logic                n_reset,
  input_conditioner_if.slave io
);

  localparam int DB_W   = $clog2(DB_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DB_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, HELD, WAIT_REL} state_t;

  // Counters stop at their terminal value instead of wrapping.
  function automatic logic [DB_W-1:0] sat_db(input logic [DB_W-1:0] c);
    return (c >= DB_MAX) ? c : c + DB_W'(1);
  endfunction

  function automatic logic [HOLD_W-1:0] sat_hold(input logic [HOLD_W-1:0] c);
    return (c >= HOLD_MAX) ? c : c + HOLD_W'(1);
  endfunction

  // Key is normalised to 1 = pressed before it enters the synchroniser.
  logic key_pol;
  assign key_pol = BTN_ACTIVE_LOW ? ~io.ready_raw : io.ready_raw;

  logic            key_s1_q, key_s2_q;
  logic [7:0]      sw_s1_q, sw_s2_q;
  logic            key_db_q, key_db_d;
  logic [DB_W-1:0] key_cnt_q, key_cnt_d;
  logic [7:0]      sw_db_q, sw_db_d;
  logic [7:0]      sw_cand_q, sw_cand_d;
  logic [DB_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [DB_W-1:0] sw_run;

  state_t             state_q, state_d;
  logic               ready_q, ready_d;
  logic [7:0]         sw_out_q, sw_out_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;

  // Key debounce: count while the synchronised key disagrees with key_db;
  // any return to agreement drops the count back to zero.
  always_comb begin
    key_db_d  = key_db_q;
    key_cnt_d = '0;
    if (key_s2_q != key_db_q) begin
      if (key_cnt_q == DB_LAST) key_db_d  = key_s2_q;
      else                      key_cnt_d = sat_db(key_cnt_q);
    end
  end

  // Switch debounce: sw_cand remembers the vector being timed, so a change
  // from one pending value to another restarts the shared count.
  always_comb begin
    sw_db_d   = sw_db_q;
    sw_cnt_d  = '0;
    sw_cand_d = sw_s2_q;
    sw_run    = (sw_s2_q == sw_cand_q) ? sw_cnt_q : '0;
    if (sw_s2_q != sw_db_q) begin
      if (sw_run == DB_LAST) sw_db_d  = sw_s2_q;
      else                   sw_cnt_d = sat_db(sw_run);
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (key_db_q)                state_d = HELD;
      HELD:     if (hold_cnt_q == HOLD_LAST) state_d = WAIT_REL;
      WAIT_REL: if (!key_db_q)               state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // FSM registered outputs; key activity is deliberately ignored in HELD.
  always_comb begin
    ready_d    = ready_q;
    hold_cnt_d = hold_cnt_q;
`ifdef INPUT_COND_SW_LIVE_EN
    sw_out_d   = sw_db_q;
`else
    sw_out_d   = sw_out_q;
`endif
    case (state_q)
      IDLE: begin
        if (key_db_q) begin
          ready_d    = 1'b1;
          hold_cnt_d = '0;
`ifndef INPUT_COND_SW_LIVE_EN
          sw_out_d   = sw_db_q;
`endif
        end
      end
      HELD: begin
        hold_cnt_d = sat_hold(hold_cnt_q);
        if (hold_cnt_q == HOLD_LAST) ready_d = 1'b0;
      end
      default: ready_d = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge fastclk or negedge n_reset) begin
    if (!n_reset) begin
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      key_db_q   <= 1'b0;
      key_cnt_q  <= '0;
      sw_db_q    <= '0;
      sw_cand_q  <= '0;
      sw_cnt_q   <= '0;
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      sw_out_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      key_s1_q   <= key_pol;
      key_s2_q   <= key_s1_q;
      sw_s1_q    <= io.sw_raw;
      sw_s2_q    <= sw_s1_q;
      key_db_q   <= key_db_d;
      key_cnt_q  <= key_cnt_d;
      sw_db_q    <= sw_db_d;
      sw_cand_q  <= sw_cand_d;
      sw_cnt_q   <= sw_cnt_d;
      state_q    <= state_d;
      ready_q    <= ready_d;
      sw_out_q   <= sw_out_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign io.ready_out = ready_q;
  assign io.sw_out    = sw_out_q;
  assign io.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_input_conditioner
// Directed stimulus for input_conditioner with DB_CYCLES=4, HOLD_CYCLES=8,
// active-low key. Every press that should produce a ready pulse pushes its
// expected rise cycle, captured switch value and high length into a queue;
// a monitor measures each ready pulse and checks it against the queue head.
// -----------------------------------------------------------------------------
module tb_input_conditioner;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 8;
  localparam int          LAT  = 2 + DB + 1;

`ifdef INPUT_COND_SW_LIVE_EN
  localparam bit LIVE = 1'b1;
`else
  localparam bit LIVE = 1'b0;
`endif

  logic fastclk = 1'b0;
  logic n_reset;

  input_conditioner_if bus ();

  input_conditioner #(
    .DB_CYCLES      (DB),
    .HOLD_CYCLES    (HOLD),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .fastclk (fastclk),
    .n_reset (n_reset),
    .io      (bus)
  );

  always #5 fastclk = ~fastclk;

  int cyc = 0;
  always @(posedge fastclk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         rise;
    logic [7:0] sw;
    int         len;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge fastclk);
  endtask

  // Ticks while insisting that no ready pulse appears.
  task automatic tick_quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge fastclk);
      chk(name, {31'd0, bus.ready_out}, 32'd0);
    end
  endtask

  // Called at the negedge where the raw key has just gone low.
  task automatic expect_pulse(input logic [7:0] sw, input int len);
    exp_t e;
    e.rise = cyc + LAT;
    e.sw   = sw;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Monitor: measure every ready pulse and score it against the queue.
  bit         in_pulse = 1'b0;
  int         cur_rise = 0;
  int         cur_len  = 0;
  logic [7:0] cur_sw   = '0;

  always @(negedge fastclk) begin
    if (bus.ready_out && !in_pulse) begin
      in_pulse = 1'b1;
      cur_rise = cyc;
      cur_sw   = bus.sw_out;
      cur_len  = 1;
    end else if (bus.ready_out) begin
      cur_len++;
    end else if (in_pulse) begin
      in_pulse = 1'b0;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse actual=rise@%0d len=%0d required=no pulse", cur_rise, cur_len);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_rise_cycle", cur_rise, e.rise);
        chk("pulse_sw_out", {24'd0, cur_sw}, {24'd0, e.sw});
        chk("pulse_high_len", cur_len, e.len);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_reset       = 1'b0;
    bus.ready_raw = 1'b1;
    bus.sw_raw    = 8'hA5;
    tick(3);
    chk("rst_ready", {31'd0, bus.ready_out}, 32'd0);
    chk("rst_busy",  {31'd0, bus.busy},      32'd0);
    chk("rst_sw",    {24'd0, bus.sw_out},    32'd0);

    // 1: idle after reset with switches at A5
    n_reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick(1);
      chk("t1_ready", {31'd0, bus.ready_out}, 32'd0);
      chk("t1_busy",  {31'd0, bus.busy},      32'd0);
      chk("t1_sw", {24'd0, bus.sw_out}, (LIVE && k >= LAT) ? 32'hA5 : 32'h00);
    end

    // 2: clean press with switches at 3C
    bus.sw_raw = 8'h3C;
    tick(10);
    bus.ready_raw = 1'b0;
    expect_pulse(8'h3C, HOLD);
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      chk("t2_ready", {31'd0, bus.ready_out}, (k >= LAT && k < LAT + HOLD) ? 32'd1 : 32'd0);
      chk("t2_busy",  {31'd0, bus.busy},      (k >= LAT) ? 32'd1 : 32'd0);
    end
    bus.ready_raw = 1'b1;
    tick(10);
    chk("t2_idle_busy", {31'd0, bus.busy}, 32'd0);
    chk("t2_sw", {24'd0, bus.sw_out}, 32'h3C);

    // 3: bounce pulses of 1, 2, 3 cycles
    for (int p = 1; p <= 3; p++) begin
      bus.ready_raw = 1'b0;
      tick_quiet(p, "t3_bounce_ready");
      bus.ready_raw = 1'b1;
      tick_quiet(1, "t3_bounce_ready");
    end
    tick_quiet(15, "t3_after_ready");
    chk("t3_busy", {31'd0, bus.busy}, 32'd0);

    // 4: switches change while HELD; key released inside HELD
    bus.ready_raw = 1'b0;
    expect_pulse(8'h3C, HOLD);
    tick(9);
    bus.sw_raw = 8'hFF;
    tick(3);
    bus.ready_raw = 1'b1;
    tick(3);
    chk("t4_sw_before", {24'd0, bus.sw_out}, 32'h3C);
    tick(1);
    chk("t4_sw_after", {24'd0, bus.sw_out}, LIVE ? 32'hFF : 32'h3C);
    tick(14);
    chk("t4_sw_late", {24'd0, bus.sw_out}, LIVE ? 32'hFF : 32'h3C);
    chk("t4_busy", {31'd0, bus.busy}, 32'd0);

    // 5: long hold, release, re-press
    bus.ready_raw = 1'b0;
    expect_pulse(8'hFF, HOLD);
    tick(30);
    chk("t5_wait_busy",  {31'd0, bus.busy},      32'd1);
    chk("t5_wait_ready", {31'd0, bus.ready_out}, 32'd0);
    tick(10);
    bus.ready_raw = 1'b1;
    tick(10);
    chk("t5_idle_busy", {31'd0, bus.busy}, 32'd0);
    bus.ready_raw = 1'b0;
    expect_pulse(8'hFF, HOLD);
    tick(20);
    bus.ready_raw = 1'b1;
    tick(15);

    // 6: reset in the third HELD cycle with the key still held
    bus.ready_raw = 1'b0;
    expect_pulse(8'hFF, 3);
    tick(LAT + 2);
    #2 n_reset = 1'b0;
    #1;
    chk("t6_rst_ready", {31'd0, bus.ready_out}, 32'd0);
    chk("t6_rst_busy",  {31'd0, bus.busy},      32'd0);
    chk("t6_rst_sw",    {24'd0, bus.sw_out},    32'd0);
    tick(2);
    n_reset = 1'b1;
    expect_pulse(8'hFF, HOLD);
    tick(3);
    chk("t6_sw_after_rst", {24'd0, bus.sw_out}, 32'd0);
    tick(17);
    bus.ready_raw = 1'b1;
    tick(15);

    chk("pending_pulses", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
